wb_stage: RTL and testbench

- Write-back stage. Consumes the MEM/WB pipeline-register outputs and drives the integer and FP register-file write ports.
- Owns the architectural HI/LO registers.
- A 64-bit FP result is written to a 32-bit FP register pair over two cycles. A one-cycle stall request holds the upstream pipeline during that sequence.

---
 rtl/wb_stage_if.sv | 46 ++++
 rtl/wb_stage.sv | 99 +++++++++
 tb/tb_wb_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM/WB-to-write-back bundle: pipeline-register outputs in, register-file
// write ports, HI/LO and the stall request out.
interface wb_stage_if;
    logic [63:0] OUT_ALU64_WB;
    logic [63:0] OUT_data64_WB;
    logic [31:0] Memory_WB;
    logic [31:0] ALU_WB;
    logic [4:0]  RegWr_WB;
    logic [31:0] HILO_write_WB;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemToReg64;
    logic        MulDiv_control;
    logic        HILO_write_control;
    logic        Jal_control;
    logic        FPwrite_control;
    logic        Load_Byte_control;
    logic        float_control_write;
    logic        Write32_64;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fp_we;
    logic [4:0]  fp_waddr;
    logic [31:0] fp_wdata;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        wb_stall;

    modport master (
        output OUT_ALU64_WB, OUT_data64_WB, Memory_WB, ALU_WB, RegWr_WB, HILO_write_WB,
               RegWrite, MemToReg, MemToReg64, MulDiv_control, HILO_write_control,
               Jal_control, FPwrite_control, Load_Byte_control, float_control_write,
               Write32_64,
        input  rf_we, rf_waddr, rf_wdata, fp_we, fp_waddr, fp_wdata, HI, LO, wb_stall
    );

    modport slave (
        input  OUT_ALU64_WB, OUT_data64_WB, Memory_WB, ALU_WB, RegWr_WB, HILO_write_WB,
               RegWrite, MemToReg, MemToReg64, MulDiv_control, HILO_write_control,
               Jal_control, FPwrite_control, Load_Byte_control, float_control_write,
               Write32_64,
        output rf_we, rf_waddr, rf_wdata, fp_we, fp_waddr, fp_wdata, HI, LO, wb_stall
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: integer/FP register-file write ports, HI/LO ownership and
// the two-cycle 64-bit FP pair write with a one-cycle upstream stall.
module wb_stage #(
    parameter int LINK_REG      = 31,
    parameter bit FP_PAIR_ALIGN = 1'b1
) (
    input logic        Clk,
    input logic        Reset,
    wb_stage_if.slave  wb
);
    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    localparam logic [4:0] LINK = 5'(LINK_REG);

    state_t      state;
    logic [31:0] upper;
    logic [4:0]  hi_addr;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        dbl;
    logic [63:0] d64;
    logic [4:0]  base;
    logic [4:0]  int_addr;

    assign dbl  = wb.FPwrite_control & wb.Write32_64;
    assign d64  = wb.MemToReg64 ? wb.OUT_data64_WB : wb.OUT_ALU64_WB;
    assign base = FP_PAIR_ALIGN ? {wb.RegWr_WB[4:1], 1'b0} : wb.RegWr_WB;

    assign int_addr = wb.Jal_control ? LINK : wb.RegWr_WB;

    always_comb begin
        wb.rf_waddr = int_addr;
        if (wb.Jal_control)
            wb.rf_wdata = wb.ALU_WB;
        else if (wb.MemToReg)
            wb.rf_wdata = wb.Load_Byte_control ? {{24{wb.Memory_WB[7]}}, wb.Memory_WB[7:0]}
                                               : wb.Memory_WB;
        else
            wb.rf_wdata = wb.ALU_WB;
        // The integer write of a double instruction already landed in IDLE.
        wb.rf_we = !Reset && (state == IDLE) && wb.RegWrite && (int_addr != 5'd0);
    end

    always_comb begin
        wb.fp_we    = 1'b0;
        wb.fp_waddr = wb.RegWr_WB;
        wb.fp_wdata = wb.OUT_ALU64_WB[31:0];
        wb.wb_stall = 1'b0;
        if (state == SECOND) begin
            wb.fp_we    = !Reset;
            wb.fp_waddr = hi_addr;
            wb.fp_wdata = upper;
        end else if (dbl) begin
            wb.fp_we    = !Reset;
            wb.fp_waddr = base;
            wb.fp_wdata = d64[31:0];
            wb.wb_stall = !Reset;
        end else begin
            wb.fp_we = !Reset && wb.FPwrite_control;
            if (wb.float_control_write)
                wb.fp_wdata = wb.ALU_WB;
            else if (wb.MemToReg)
                wb.fp_wdata = wb.Memory_WB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            upper   <= '0;
            hi_addr <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbl) begin
                        state   <= SECOND;
                        upper   <= d64[63:32];
                        hi_addr <= base + 5'd1;
                    end
                    if (wb.MulDiv_control) begin
                        hi_reg <= wb.OUT_ALU64_WB[63:32];
                        lo_reg <= wb.OUT_ALU64_WB[31:0];
                    end else if (wb.HILO_write_control) begin
                        if (wb.RegWr_WB[0]) hi_reg <= wb.HILO_write_WB;
                        else                lo_reg <= wb.HILO_write_WB;
                    end
                end
                SECOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.HI = hi_reg;
    assign wb.LO = lo_reg;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors for integer, FP single,
// FP double, HI/LO and reset behaviour.
module tb_wb_stage;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_stage_if bus ();

    wb_stage #(.LINK_REG(31), .FP_PAIR_ALIGN(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.OUT_ALU64_WB        = '0;
        bus.OUT_data64_WB       = '0;
        bus.Memory_WB           = '0;
        bus.ALU_WB              = '0;
        bus.RegWr_WB            = '0;
        bus.HILO_write_WB       = '0;
        bus.RegWrite            = 1'b0;
        bus.MemToReg            = 1'b0;
        bus.MemToReg64          = 1'b0;
        bus.MulDiv_control      = 1'b0;
        bus.HILO_write_control  = 1'b0;
        bus.Jal_control         = 1'b0;
        bus.FPwrite_control     = 1'b0;
        bus.Load_Byte_control   = 1'b0;
        bus.float_control_write = 1'b0;
        bus.Write32_64          = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_double();
        clear_in();
        bus.FPwrite_control = 1'b1;
        bus.Write32_64      = 1'b1;
        bus.MemToReg64      = 1'b1;
        bus.OUT_data64_WB   = 64'h4009_21FB_5444_2D18;
        bus.RegWr_WB        = 5'd5;
    endtask

    initial begin
        clear_in();
        // Reset with every control high
        bus.RegWrite = 1; bus.MemToReg = 1; bus.MemToReg64 = 1; bus.MulDiv_control = 1;
        bus.HILO_write_control = 1; bus.Jal_control = 1; bus.FPwrite_control = 1;
        bus.Load_Byte_control = 1; bus.float_control_write = 1; bus.Write32_64 = 1;
        bus.OUT_ALU64_WB = 64'hDEAD_BEEF_CAFE_F00D;
        bus.RegWr_WB = 5'd7;
        tick();
        tick();
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_fp_we", 64'(bus.fp_we), 64'd0);
        chk("rst_stall", 64'(bus.wb_stall), 64'd0);
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);

        clear_in();
        Reset = 1'b0;
        bus.RegWrite = 1; bus.RegWr_WB = 5'd3; bus.ALU_WB = 32'h0000_0011;
        #1;
        chk("post_rst_we", 64'(bus.rf_we), 64'd1);
        chk("post_rst_data", 64'(bus.rf_wdata), 64'h11);

        // Signed byte load
        clear_in();
        bus.RegWrite = 1; bus.MemToReg = 1; bus.Load_Byte_control = 1;
        bus.Memory_WB = 32'h0000_00F3; bus.RegWr_WB = 5'd8;
        #1;
        chk("lb_we", 64'(bus.rf_we), 64'd1);
        chk("lb_addr", 64'(bus.rf_waddr), 64'd8);
        chk("lb_data", 64'(bus.rf_wdata), 64'hFFFF_FFF3);
        bus.Load_Byte_control = 0; bus.Memory_WB = 32'h8000_00F3;
        #1;
        chk("lw_data", 64'(bus.rf_wdata), 64'h8000_00F3);
        bus.RegWr_WB = 5'd0;
        #1;
        chk("r0_we", 64'(bus.rf_we), 64'd0);

        // Jal
        clear_in();
        bus.Jal_control = 1; bus.RegWrite = 1; bus.ALU_WB = 32'h0040_0010;
        bus.MemToReg = 1; bus.Memory_WB = 32'h1234_0000; bus.RegWr_WB = 5'd2;
        #1;
        chk("jal_addr", 64'(bus.rf_waddr), 64'd31);
        chk("jal_data", 64'(bus.rf_wdata), 64'h0040_0010);
        chk("jal_we", 64'(bus.rf_we), 64'd1);

        // FP single writes
        clear_in();
        bus.FPwrite_control = 1; bus.RegWr_WB = 5'd9; bus.float_control_write = 1;
        bus.ALU_WB = 32'h3F80_0000; bus.MemToReg = 1; bus.Memory_WB = 32'h4000_0000;
        bus.OUT_ALU64_WB = 64'h1111_2222_3333_4444;
        #1;
        chk("fps_we", 64'(bus.fp_we), 64'd1);
        chk("fps_addr", 64'(bus.fp_waddr), 64'd9);
        chk("fps_alu", 64'(bus.fp_wdata), 64'h3F80_0000);
        bus.float_control_write = 0;
        #1;
        chk("fps_mem", 64'(bus.fp_wdata), 64'h4000_0000);
        bus.MemToReg = 0;
        #1;
        chk("fps_a64", 64'(bus.fp_wdata), 64'h3333_4444);
        chk("fps_stall", 64'(bus.wb_stall), 64'd0);

        // FP double; integer write in the same instruction
        tick();
        set_double();
        bus.RegWrite = 1; bus.RegWr_WB = 5'd5; bus.ALU_WB = 32'h77;
        #1;
        chk("dbl1_we", 64'(bus.fp_we), 64'd1);
        chk("dbl1_addr", 64'(bus.fp_waddr), 64'd4);
        chk("dbl1_data", 64'(bus.fp_wdata), 64'h5444_2D18);
        chk("dbl1_stall", 64'(bus.wb_stall), 64'd1);
        chk("dbl1_rf_we", 64'(bus.rf_we), 64'd1);
        tick();
        chk("dbl2_we", 64'(bus.fp_we), 64'd1);
        chk("dbl2_addr", 64'(bus.fp_waddr), 64'd5);
        chk("dbl2_data", 64'(bus.fp_wdata), 64'h4009_21FB);
        chk("dbl2_stall", 64'(bus.wb_stall), 64'd0);
        chk("dbl2_rf_we", 64'(bus.rf_we), 64'd0);
        // Held inputs after SECOND start a fresh sequence with no gap
        tick();
        chk("b2b_stall", 64'(bus.wb_stall), 64'd1);
        chk("b2b_addr", 64'(bus.fp_waddr), 64'd4);
        tick();
        chk("b2b2_addr", 64'(bus.fp_waddr), 64'd5);
        clear_in();
        tick();
        chk("idle_fp_we", 64'(bus.fp_we), 64'd0);
        chk("idle_stall", 64'(bus.wb_stall), 64'd0);

        // HI/LO: MulDiv wins over HILO write
        bus.MulDiv_control = 1; bus.HILO_write_control = 1;
        bus.OUT_ALU64_WB = 64'h1234_5678_9ABC_DEF0; bus.HILO_write_WB = 32'hFFFF_0000;
        bus.RegWr_WB = 5'd1;
        tick();
        chk("md_hi", 64'(bus.HI), 64'h1234_5678);
        chk("md_lo", 64'(bus.LO), 64'h9ABC_DEF0);
        bus.MulDiv_control = 0; bus.RegWr_WB = 5'd0; bus.HILO_write_WB = 32'hA5A5_A5A5;
        tick();
        chk("mtlo_lo", 64'(bus.LO), 64'hA5A5_A5A5);
        chk("mtlo_hi", 64'(bus.HI), 64'h1234_5678);
        bus.RegWr_WB = 5'd1; bus.HILO_write_WB = 32'h0BAD_F00D;
        tick();
        chk("mthi_hi", 64'(bus.HI), 64'h0BAD_F00D);
        chk("mthi_lo", 64'(bus.LO), 64'hA5A5_A5A5);

        // HI/LO ignored in SECOND
        set_double();
        tick();
        bus.MulDiv_control = 1; bus.OUT_ALU64_WB = 64'h5555_5555_6666_6666;
        tick();
        chk("sec_hi", 64'(bus.HI), 64'h0BAD_F00D);
        clear_in();
        tick();

        // Reset during SECOND
        set_double();
        tick();
        chk("rs_in_second", 64'(bus.fp_waddr), 64'd5);
        Reset = 1'b1;
        #1;
        chk("rs_fp_we_now", 64'(bus.fp_we), 64'd0);
        tick();
        chk("rs_fp_we", 64'(bus.fp_we), 64'd0);
        chk("rs_stall", 64'(bus.wb_stall), 64'd0);
        chk("rs_hi", 64'(bus.HI), 64'd0);
        chk("rs_lo", 64'(bus.LO), 64'd0);
        Reset = 1'b0;
        #1;
        // Back in IDLE: held double inputs present the first half again
        chk("rs_idle_stall", 64'(bus.wb_stall), 64'd1);
        chk("rs_idle_addr", 64'(bus.fp_waddr), 64'd4);
        clear_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
